kbd_event_ctrl: RTL

Sequencing controller between the PS/2 receiver FIFO (`ps2_keyboard`) and the CPU/MMIO side. It pops raw scan-code bytes with the receiver's `nextdata_n` handshake, parses `E0`/`F0` prefixes and tracks modifier state. Decoded make/break events go into an internal event FIFO that a consumer drains through a valid/ready port.

---
 rtl/kbd_event_ctrl_if.sv | 41 ++++
 rtl/kbd_event_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/kbd_event_ctrl_if.sv
// kbd_event_ctrl bus: PS/2 receiver FIFO pop side plus
// the decoded-event valid/ready consumer port.
interface kbd_event_ctrl_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          ps2_ready;
  logic [7:0]    ps2_data;
  logic          ps2_overflow;
  logic          ps2_nextdata_n;
  logic          evt_valid;
  logic          evt_ready;
  logic [9:0]    evt_data;
  logic [2:0]    evt_mods;
  logic [CW-1:0] evt_count;

  modport master (
    input  ps2_ready,
    input  ps2_data,
    input  ps2_overflow,
    input  evt_ready,
    output ps2_nextdata_n,
    output evt_valid,
    output evt_data,
    output evt_mods,
    output evt_count
  );

  modport slave (
    output ps2_ready,
    output ps2_data,
    output ps2_overflow,
    output evt_ready,
    input  ps2_nextdata_n,
    input  evt_valid,
    input  evt_data,
    input  evt_mods,
    input  evt_count
  );
endinterface

// File: rtl/kbd_event_ctrl.sv
// PS/2 scan-code sequencer, modifier tracker and event FIFO.
// Optional make-repeat suppression: KBD_TYPEMATIC_FILTER_EN.
module kbd_event_ctrl #(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  kbd_event_ctrl_if.master bus,
  output logic             ctrl_led,
  output logic             shift_led,
  output logic             caps_led,
  output logic             err_drop,
  output logic             err_ovf,
  input  logic             err_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    ACK,
    PARSE
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] byte_q;
  logic       nd_q, nd_d;
  logic       latch;
  logic       ext_q, ext_d;
  logic       brk_q, brk_d;
  logic       ctrl_q, ctrl_d;
  logic       shift_q, shift_d;
  logic       caps_q, caps_d;
  logic       held_q, held_d;
  logic       is_evt;
  logic       filt_hit;
  logic       push;

  always_comb begin
    state_d = state_q;
    nd_d    = 1'b1;
    latch   = 1'b0;
    ext_d   = ext_q;
    brk_d   = brk_q;
    ctrl_d  = ctrl_q;
    shift_d = shift_q;
    caps_d  = caps_q;
    held_d  = held_q;
    is_evt  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.ps2_ready) begin
          latch   = 1'b1;
          nd_d    = 1'b0;
          state_d = ACK;
        end
      end
      ACK: state_d = PARSE;
      PARSE: begin
        state_d = IDLE;
        unique case (byte_q)
          8'hE0: ext_d = 1'b1;
          8'hF0: brk_d = 1'b1;
          8'hAA, 8'hFA, 8'hE1: ;
          default: begin
            is_evt = 1'b1;
            ext_d  = 1'b0;
            brk_d  = 1'b0;
            unique case (byte_q)
              8'h14: ctrl_d = !brk_q;
              8'h12, 8'h59: shift_d = !brk_q;
              8'h58: begin
                // caps toggles once per physical press
                if (brk_q) begin
                  held_d = 1'b0;
                end else begin
                  if (!held_q) caps_d = !caps_q;
                  held_d = 1'b1;
                end
              end
              default: ;
            endcase
          end
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef KBD_TYPEMATIC_FILTER_EN
  logic       trk_v_q;
  logic [8:0] trk_q;
  logic       trk_match;

  assign trk_match = trk_v_q && (trk_q == {ext_q, byte_q});
  assign filt_hit  = is_evt && !brk_q && trk_match;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      trk_v_q <= 1'b0;
      trk_q   <= '0;
    end else if (is_evt) begin
      if (!brk_q) begin
        trk_v_q <= 1'b1;
        trk_q   <= {ext_q, byte_q};
      end else if (trk_match) begin
        trk_v_q <= 1'b0;
      end
    end
  end
`else
  assign filt_hit = 1'b0;
`endif

  assign push = is_evt && !filt_hit;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      nd_q    <= 1'b1;
      byte_q  <= '0;
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
      ctrl_q  <= 1'b0;
      shift_q <= 1'b0;
      caps_q  <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      nd_q    <= nd_d;
      if (latch) byte_q <= bus.ps2_data;
      ext_q   <= ext_d;
      brk_q   <= brk_d;
      ctrl_q  <= ctrl_d;
      shift_q <= shift_d;
      caps_q  <= caps_d;
      held_q  <= held_d;
    end
  end

  logic [9:0]    data_mem [DEPTH];
  logic [2:0]    mods_mem [DEPTH];
  logic [CW-1:0] wr_q, rd_q, count;
  logic          full, empty, pop, wr_en, drop;

  assign count = wr_q - rd_q;
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign pop   = bus.evt_ready && !empty;
  // a full FIFO still takes a push when the head leaves this cycle
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_mem[wr_q[AW-1:0]] <= {ext_q, brk_q, byte_q};
      mods_mem[wr_q[AW-1:0]] <= {caps_d, shift_d, ctrl_d};
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wr_q     <= '0;
      rd_q     <= '0;
      err_drop <= 1'b0;
      err_ovf  <= 1'b0;
    end else begin
      if (wr_en) wr_q <= wr_q + 1'b1;
      if (pop)   rd_q <= rd_q + 1'b1;
      if (drop)         err_drop <= 1'b1;
      else if (err_clr) err_drop <= 1'b0;
      if (bus.ps2_overflow) err_ovf <= 1'b1;
      else if (err_clr)     err_ovf <= 1'b0;
    end
  end

  assign bus.ps2_nextdata_n = nd_q;
  assign bus.evt_valid      = !empty;
  assign bus.evt_count      = count;
  assign bus.evt_data       = empty ? '0 : data_mem[rd_q[AW-1:0]];
  assign bus.evt_mods       = empty ? '0 : mods_mem[rd_q[AW-1:0]];
  assign ctrl_led           = ctrl_q;
  assign shift_led          = shift_q;
  assign caps_led           = caps_q;

endmodule
